// File: rtl/param_fifo_pkg.sv
// Shared defaults and the per-cycle operation encoding for the parameterised FIFO.
package param_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DEPTH      = 8;
   localparam int DEF_AF_LEVEL   = 6;
   localparam int DEF_AE_LEVEL   = 2;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_PUSH = 2'd1,
      OP_POP  = 2'd2,
      OP_BOTH = 2'd3
   } fifo_op_e;

endpackage

// File: rtl/param_fifo_mem.sv
// FIFO storage: registered write, asynchronous (show-ahead) read, no reset on the array.
module param_fifo_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_WIDTH-1:0]    rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO control: pointers, occupancy count, registered level flags and sticky errors.
module param_fifo
   import param_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int AF_LEVEL   = DEF_AF_LEVEL,
   parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     wr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic                     rd,
   output logic [DATA_WIDTH-1:0]    rdata,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     err_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("param_fifo: DEPTH must be a power of two and at least 2");
      end
      if (AE_LEVEL < 1 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH - 1) begin : g_bad_levels
         $error("param_fifo: need 1 <= AE_LEVEL < AF_LEVEL <= DEPTH-1");
      end
   endgenerate

   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count_nxt;
   logic          push_ok, pop_ok;
   fifo_op_e      op;

   // Acceptance uses the registered flags so a full FIFO never takes a same-cycle push.
   assign push_ok = wr & ~full;
   assign pop_ok  = rd & ~empty;

   always_comb begin
      op = OP_NONE;
      case ({pop_ok, push_ok})
         2'b01:   op = OP_PUSH;
         2'b10:   op = OP_POP;
         2'b11:   op = OP_BOTH;
         default: op = OP_NONE;
      endcase
   end

   always_comb begin
      count_nxt = count;
      case (op)
         OP_PUSH: count_nxt = count + CW'(1);
         OP_POP:  count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   param_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push_ok & ~flush & ~rst),
      .waddr (wptr),
      .wdata (wdata),
      .raddr (rptr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else if (flush) begin
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         // Power-of-two depth lets the pointers wrap by natural overflow.
         if (push_ok) wptr <= wptr + AW'(1);
         if (pop_ok)  rptr <= rptr + AW'(1);
         count        <= count_nxt;
         full         <= (count_nxt == FULL_CNT);
         empty        <= (count_nxt == '0);
         almost_full  <= (count_nxt >= AF_CNT);
         almost_empty <= (count_nxt <= AE_CNT);

         if (wr & full)    overflow <= 1'b1;
         else if (err_clr) overflow <= 1'b0;

         if (rd & empty)   underflow <= 1'b1;
         else if (err_clr) underflow <= 1'b0;
      end
   end

endmodule
